// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point round/pack back end.
package fp_pkg;

    // IEEE 754 rounding directions as encoded on the rounding-mode input.
    typedef enum logic [2:0] {
        RND_RNE = 3'b000,
        RND_RTZ = 3'b001,
        RND_RDN = 3'b010,
        RND_RUP = 3'b011,
        RND_RMM = 3'b100
    } rnd_mode_e;

    localparam logic [7:0]  FP32_EXP_MAX    = 8'hFF;
    localparam logic [30:0] FP32_MAX_FINITE = 31'h7F7FFFFF;
    localparam logic [30:0] FP32_INF_MAG    = 31'h7F800000;

    // Bit positions inside the 4-bit exception flag vector {NV, OF, UF, NX}.
    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Everything stage 2 needs to finish rounding and packing one beat.
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
        logic        inc;
        logic        nx;
        logic [2:0]  mode;
        logic        special;
        logic [31:0] special_val;
        logic        nv;
    } round_stage_t;

    // Unused encodings fall back to round-to-nearest-even.
    function automatic rnd_mode_e decode_mode(input logic [2:0] mode);
        rnd_mode_e m;
        case (mode)
            3'b001:  m = RND_RTZ;
            3'b010:  m = RND_RDN;
            3'b011:  m = RND_RUP;
            3'b100:  m = RND_RMM;
            default: m = RND_RNE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/fp_round_decide.sv
// Combinational rounding decision: from the mantissa LSB and the guard,
// round and sticky bits, decide whether to increment and whether the
// result is inexact. Kept separate so other datapaths can reuse it.
module fp_round_decide
    import fp_pkg::*;
(
    input  logic       sign,
    input  logic [3:0] round_bits,   // {lsb, G, R, S}
    input  logic [2:0] rnd_mode,
    output logic       inc,
    output logic       nx
);

    logic lsb;
    logic g_bit;
    logic r_bit;
    logic s_bit;

    assign lsb   = round_bits[3];
    assign g_bit = round_bits[2];
    assign r_bit = round_bits[1];
    assign s_bit = round_bits[0];

    // Pick the increment rule for the requested rounding direction.
    always_comb begin
        nx  = g_bit | r_bit | s_bit;
        inc = 1'b0;
        case (decode_mode(rnd_mode))
            RND_RTZ: inc = 1'b0;
            RND_RDN: inc = nx & sign;
            RND_RUP: inc = nx & ~sign;
            RND_RMM: inc = g_bit;
            default: inc = g_bit & (r_bit | s_bit | lsb);
        endcase
    end

endmodule

// File: rtl/fp_round_pack.sv
// Round and pack back end of the FP add/sub datapath. Stage 1 decides the
// rounding increment and inexactness, stage 2 applies it, handles carry-out,
// subnormal promotion and overflow, and registers the packed binary32 word
// plus exception flags. Two-stage valid/ready pipeline, one beat per cycle.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W-1:0]       in_exponent,
    input  logic [MAN_W+3:0]       in_mant_ext,
    input  logic [2:0]             in_rnd_mode,
    input  logic                   in_special,
    input  logic [EXP_W+MAN_W:0]   in_special_val,
    input  logic                   in_nv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic [3:0]             out_flags
);

    round_stage_t               s1_reg;
    round_stage_t               s1_next;
    logic                       s1_valid_reg;
    logic                       s2_valid_reg;
    logic [EXP_W+MAN_W:0]       out_result_reg;
    logic [3:0]                 out_flags_reg;

    logic                       s2_load;
    logic                       dec_inc;
    logic                       dec_nx;

    logic [MAN_W+1:0]           sum;
    logic [EXP_W:0]             exp_final;
    logic [MAN_W-1:0]           frac_final;
    logic                       ovf;
    logic                       is_zero;
    logic [30:0]                ovf_mag;
    logic [EXP_W+MAN_W:0]       result_next;
    logic [3:0]                 flags_next;

    // Stage 2 may refill whenever its output is empty or being taken;
    // stage 1 may refill whenever it is empty or moving into stage 2.
    assign s2_load  = ~s2_valid_reg | out_ready;
    assign in_ready = ~s1_valid_reg | s2_load;

    fp_round_decide u_decide (
        .sign       (in_sign),
        .round_bits (in_mant_ext[3:0]),
        .rnd_mode   (in_rnd_mode),
        .inc        (dec_inc),
        .nx         (dec_nx)
    );

    // Collect the stage-1 payload from the input beat.
    always_comb begin
        s1_next             = '0;
        s1_next.sign        = in_sign;
        s1_next.exp         = in_exponent;
        s1_next.mant        = in_mant_ext[MAN_W+3:3];
        s1_next.inc         = dec_inc;
        s1_next.nx          = dec_nx;
        s1_next.mode        = decode_mode(in_rnd_mode);
        s1_next.special     = in_special;
        s1_next.special_val = in_special_val;
        s1_next.nv          = in_nv;
    end

    // Stage-1 register: accepts a new beat whenever in_ready is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_reg       <= '0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_reg <= s1_next;
            end
        end
    end

    // Apply the increment, fix up the exponent, and pack result and flags.
    always_comb begin
        sum         = {1'b0, s1_reg.mant} + {{(MAN_W+1){1'b0}}, s1_reg.inc};
        exp_final   = {1'b0, s1_reg.exp};
        frac_final  = sum[MAN_W-1:0];
        is_zero     = (s1_reg.mant == '0) && !s1_reg.nx;
        ovf_mag     = FP32_INF_MAG;
        result_next = '0;
        flags_next  = '0;

        if (sum[MAN_W+1]) begin
            // Mantissa rounded up to 2.0: renormalize to 1.0 with exp+1.
            exp_final  = exp_final + 1'b1;
            frac_final = '0;
        end else if (s1_reg.exp == '0 && sum[MAN_W]) begin
            // Largest subnormal rounded up into the smallest normal.
            exp_final = {{EXP_W{1'b0}}, 1'b1};
        end

        ovf = (exp_final >= {1'b0, FP32_EXP_MAX});

        case (decode_mode(s1_reg.mode))
            RND_RTZ: ovf_mag = FP32_MAX_FINITE;
            RND_RDN: ovf_mag = s1_reg.sign ? FP32_INF_MAG : FP32_MAX_FINITE;
            RND_RUP: ovf_mag = s1_reg.sign ? FP32_MAX_FINITE : FP32_INF_MAG;
            default: ovf_mag = FP32_INF_MAG;
        endcase

        flags_next[FLAG_NV] = s1_reg.nv;
        if (s1_reg.special) begin
            result_next = s1_reg.special_val;
        end else if (is_zero) begin
            result_next = {s1_reg.sign, {(EXP_W+MAN_W){1'b0}}};
        end else if (ovf) begin
            result_next         = {s1_reg.sign, ovf_mag};
            flags_next[FLAG_OF] = 1'b1;
            flags_next[FLAG_NX] = 1'b1;
        end else begin
            result_next         = {s1_reg.sign, exp_final[EXP_W-1:0], frac_final};
            flags_next[FLAG_NX] = s1_reg.nx;
            flags_next[FLAG_UF] = (exp_final == '0) && s1_reg.nx;
        end
    end

    // Stage-2 output register: holds steady while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg   <= 1'b0;
            out_result_reg <= '0;
            out_flags_reg  <= '0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_result_reg <= result_next;
                out_flags_reg  <= flags_next;
            end
        end
    end

    assign out_valid  = s2_valid_reg;
    assign out_result = out_result_reg;
    assign out_flags  = out_flags_reg;

endmodule
